// File: rtl/accel_pkg.sv
// Shared accelerator definitions: lane width default, feeder FSM states and
// the width helper used to size the flush counter.
package accel_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fsm_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Upstream vector stream into the feeder: valid/ready handshake plus a
// tile-last qualifier; one column vector per beat.
interface systolic_feeder_if #(
  parameter int N      = 4,
  parameter int DATA_W = accel_pkg::DATA_W
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0][DATA_W-1:0]   in_data;
  logic                       in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Enable-gated delay line; one per array row, DEPTH sets that row's skew.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = accel_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DEPTH-1:0][DATA_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Skews column vectors onto the west edge of an N-row systolic array, then
// flushes zeros for 2N-2 steps so the last vector drains through every row.
module systolic_feeder
  import accel_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = accel_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_feeder_if.slave         up,
  output logic [N-1:0][DATA_W-1:0] west_out,
  output logic                     ce,
  output logic                     busy,
  output logic                     tile_done
);
  localparam int             FCW        = clog2(2*N-1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(2*N-3);

  fsm_state_t               state, state_nxt;
  logic [FCW-1:0]           fcnt;
  logic                     accept, adv, last_flush;
  logic [N-1:0][DATA_W-1:0] lane_in;
  logic [1:0]               done_pipe;

  assign accept     = up.in_valid && up.in_ready;
  assign adv        = accept || (state == FLUSH);
  assign last_flush = (state == FLUSH) && (fcnt == FLUSH_LAST);
  assign lane_in    = (state == FLUSH) ? '0 : up.in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, STREAM: if (accept) state_nxt = up.in_last ? FLUSH : STREAM;
      FLUSH:        if (last_flush) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Ready drops combinationally with rst so nothing is accepted during reset.
  always_comb begin
    up.in_ready = !rst && (state != FLUSH);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt      <= '0;
      ce        <= 1'b0;
      done_pipe <= '0;
    end else begin
      fcnt      <= (state == FLUSH && !last_flush) ? fcnt + 1'b1 : '0;
      ce        <= adv;
      // Done trails the last flush advance by two: one for ce, one for the PE step.
      done_pipe <= {done_pipe[0], last_flush};
    end
  end

  assign tile_done = done_pipe[1];

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.DEPTH(g+1), .DATA_W(DATA_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .d   (lane_in[g]),
      .q   (west_out[g])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4) including a 4x4 output-stationary
// PE array fed west and north by two feeders.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 16;
  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .DATA_W(DW)) wif();
  systolic_feeder_if #(.N(N), .DATA_W(DW)) nif();

  vec_t west_out, north_out;
  logic ce, busy, tile_done, n_ce, n_busy, n_done;

  systolic_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .up(wif.slave), .west_out(west_out),
    .ce(ce), .busy(busy), .tile_done(tile_done));

  systolic_feeder #(.N(N), .DATA_W(DW)) u_north (
    .clk(clk), .rst(rst), .up(nif.slave), .west_out(north_out),
    .ce(n_ce), .busy(n_busy), .tile_done(n_done));

  assign nif.in_valid = wif.in_valid;
  assign nif.in_data  = wif.in_data;
  assign nif.in_last  = wif.in_last;

  int n_cmp = 0;
  int n_err = 0;

  // Output-stationary PE array: west data moves east, north data moves south.
  int   acc [N][N];
  int   ar  [N][N];
  int   br  [N][N];
  logic pe_clr = 1'b0;

  function automatic int pe_a(input int i, input int j);
    return (j == 0) ? int'(west_out[i]) : ar[i][j-1];
  endfunction

  function automatic int pe_b(input int i, input int j);
    return (i == 0) ? int'(north_out[j]) : br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (pe_clr) begin
          acc[i][j] <= 0; ar[i][j] <= 0; br[i][j] <= 0;
        end else if (ce === 1'b1) begin
          acc[i][j] <= acc[i][j] + pe_a(i, j) * pe_b(i, j);
          ar[i][j]  <= pe_a(i, j);
          br[i][j]  <= pe_b(i, j);
        end
      end
  end

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = DW'(a); v[1] = DW'(b); v[2] = DW'(c); v[3] = DW'(d);
    return v;
  endfunction

  task automatic drive(input logic v, input vec_t d, input logic l);
    wif.in_valid = v;
    wif.in_data  = d;
    wif.in_last  = l;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, '0, 1'b0);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (west_out !== '0) begin n_err++; $display("FAIL reset_west: got %h want 0", west_out); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b want 0", ce); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tile_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", tile_done); end
    n_cmp++; if (wif.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst: got %b want 0", wif.in_ready); end
    tick; tick;
    @(negedge clk) rst = 1'b0;
    tick;
    n_cmp++; if (wif.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", wif.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_after: got %b want 0", busy); end
  endtask

  // One vector with in_last: 7 ce cycles, lane i carries i+1 in ce cycle i+1.
  task automatic test_single;
    logic [DW-1:0] exp_l;
    drive(1'b1, mk(1, 2, 3, 4), 1'b1);
    for (int t = 0; t < 10; t++) begin
      tick;
      if (t == 0) drive(1'b0, '0, 1'b0);
      n_cmp++; if (ce !== (t <= 6)) begin n_err++; $display("FAIL single_ce t=%0d: got %b want %b", t, ce, t <= 6); end
      n_cmp++; if (tile_done !== (t == 7)) begin n_err++; $display("FAIL single_done t=%0d: got %b want %b", t, tile_done, t == 7); end
      n_cmp++; if (wif.in_ready !== (t >= 6)) begin n_err++; $display("FAIL single_ready t=%0d: got %b want %b", t, wif.in_ready, t >= 6); end
      n_cmp++; if (busy !== (t <= 5)) begin n_err++; $display("FAIL single_busy t=%0d: got %b want %b", t, busy, t <= 5); end
      for (int i = 0; i < N; i++) begin
        exp_l = (t == i) ? DW'(i + 1) : '0;
        n_cmp++; if (west_out[i] !== exp_l) begin n_err++; $display("FAIL single_lane%0d t=%0d: got %h want %h", i, t, west_out[i], exp_l); end
      end
    end
  endtask

  // Three vectors with two idle cycles between; skew must be gap-invariant.
  task automatic test_gaps;
    logic sv [7];
    vec_t exp_w;
    int   c, k, vi;
    sv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_w = '0;
    c  = 0;
    vi = 0;
    for (int t = 0; t < 16; t++) begin
      if (t < 7 && sv[t]) begin
        vi++;
        drive(1'b1, mk(16*vi + 1, 16*vi + 2, 16*vi + 3, 16*vi + 4), t == 6);
      end else begin
        drive(1'b0, '0, 1'b0);
      end
      tick;
      if ((t < 7) ? sv[t] : (t <= 12)) begin
        c++;
        for (int i = 0; i < N; i++) begin
          k = c - i;
          exp_w[i] = (k >= 1 && k <= 3) ? DW'(16*k + i + 1) : '0;
        end
      end
      n_cmp++; if (ce !== ((t < 7) ? sv[t] : (t <= 12))) begin n_err++; $display("FAIL gaps_ce t=%0d: got %b", t, ce); end
      n_cmp++; if (west_out !== exp_w) begin n_err++; $display("FAIL gaps_west t=%0d: got %h want %h", t, west_out, exp_w); end
      n_cmp++; if (tile_done !== (t == 13)) begin n_err++; $display("FAIL gaps_done t=%0d: got %b want %b", t, tile_done, t == 13); end
    end
    n_cmp++; if (c !== 9) begin n_err++; $display("FAIL gaps_ce_count: got %0d want 9", c); end
  endtask

  // Next tile held valid through FLUSH: ignored until ready returns.
  task automatic test_backpressure;
    logic [DW-1:0] exp0;
    logic          exp_rdy;
    drive(1'b1, mk(5, 6, 7, 8), 1'b1);
    for (int t = 0; t < 16; t++) begin
      tick;
      if (t == 0) drive(1'b1, mk(9, 10, 11, 12), 1'b1);
      if (t == 7) drive(1'b0, '0, 1'b0);
      exp_rdy = (t == 6) || (t >= 13);
      exp0 = (t == 0) ? DW'(5) : (t == 7) ? DW'(9) : '0;
      n_cmp++; if (wif.in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_ready t=%0d: got %b want %b", t, wif.in_ready, exp_rdy); end
      n_cmp++; if (west_out[0] !== exp0) begin n_err++; $display("FAIL bp_lane0 t=%0d: got %h want %h", t, west_out[0], exp0); end
      n_cmp++; if (tile_done !== (t == 7 || t == 14)) begin n_err++; $display("FAIL bp_done t=%0d: got %b", t, tile_done); end
      n_cmp++; if (ce !== (t <= 13)) begin n_err++; $display("FAIL bp_ce t=%0d: got %b want %b", t, ce, t <= 13); end
    end
  endtask

  // Reset in the third flush cycle aborts the tile; the next tile runs clean.
  task automatic test_reset_mid_flush;
    int ce_cnt, busy_cnt, done_cnt;
    drive(1'b1, mk(1, 2, 3, 4), 1'b1);
    tick;
    drive(1'b0, '0, 1'b0);
    tick; tick;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (west_out !== '0) begin n_err++; $display("FAIL rmf_west: got %h want 0", west_out); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rmf_ce: got %b want 0", ce); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmf_busy: got %b want 0", busy); end
    n_cmp++; if (wif.in_ready !== 1'b0) begin n_err++; $display("FAIL rmf_ready: got %b want 0", wif.in_ready); end
    tick;
    @(negedge clk) rst = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (tile_done === 1'b1) done_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL rmf_no_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmf_idle: got busy %b want 0", busy); end
    drive(1'b1, mk(7, 7, 7, 7), 1'b1);
    ce_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      tick;
      if (t == 0) drive(1'b0, '0, 1'b0);
      if (ce === 1'b1) ce_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (tile_done === 1'b1) begin
        done_cnt++;
        n_cmp++; if (t !== 7) begin n_err++; $display("FAIL rmf_done_time: got t=%0d want 7", t); end
      end
    end
    n_cmp++; if (ce_cnt !== 7) begin n_err++; $display("FAIL rmf_ce_count: got %0d want 7", ce_cnt); end
    n_cmp++; if (busy_cnt !== 6) begin n_err++; $display("FAIL rmf_flush_len: got %0d want 6", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rmf_done_count: got %0d want 1", done_cnt); end
  endtask

  // Identity x identity through the PE array; checked at tile_done.
  task automatic test_e2e;
    vec_t v;
    logic seen;
    int   exp_acc;
    pe_clr = 1'b1;
    tick;
    pe_clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      v = '0;
      v[k] = DW'(1);
      drive(1'b1, v, k == N-1);
      tick;
    end
    drive(1'b0, '0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      if (tile_done === 1'b1) seen = 1'b1;
      else tick;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL e2e_timeout: got no tile_done want pulse"); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_acc = (i == j) ? 1 : 0;
        n_cmp++; if (acc[i][j] !== exp_acc) begin n_err++; $display("FAIL e2e_acc[%0d][%0d]: got %0d want %0d", i, j, acc[i][j], exp_acc); end
      end
  endtask

  initial begin
    test_reset;
    test_single;
    test_gaps;
    test_backpressure;
    test_reset_mid_flush;
    test_e2e;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
